// File: rtl/cpu_pkg.sv
// Shared types and default widths for the instruction store.
package cpu_pkg;

  localparam int unsigned IMEM_INSTR_W = 19;
  localparam int unsigned IMEM_ADDR_W  = 12;

  localparam logic [IMEM_INSTR_W-1:0] IMEM_NOP_WORD = '0;

  typedef enum logic {
    IMEM_CLEAR = 1'b0,
    IMEM_RUN   = 1'b1
  } imem_state_t;

endpackage

// File: rtl/instr_mem_loadable_if.sv
// Program-load and fetch bus of the instruction store.
// master = loader/fetch side, slave = memory side.
interface instr_mem_loadable_if
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = IMEM_ADDR_W,
  parameter int unsigned INSTR_W = IMEM_INSTR_W
);

  logic               ld_valid;
  logic               ld_ready;
  logic [ADDR_W-1:0]  ld_addr;
  logic [INSTR_W-1:0] ld_data;
  logic               ld_last;
  logic               ld_err;

  logic               fetch_req;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               fetch_valid;
  logic [INSTR_W-1:0] fetch_instr;
  logic               fetch_err;

  modport master (
    output ld_valid, ld_addr, ld_data, ld_last, fetch_req, fetch_addr,
    input  ld_ready, ld_err, fetch_valid, fetch_instr, fetch_err
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_last, fetch_req, fetch_addr,
    output ld_ready, ld_err, fetch_valid, fetch_instr, fetch_err
  );

endinterface

// File: rtl/imem_ram.sv
// DEPTH x INSTR_W storage: one write port (clear or load), one read-first read port.
module imem_ram
  import cpu_pkg::*;
#(
  parameter int unsigned        INSTR_W  = IMEM_INSTR_W,
  parameter int unsigned        DEPTH    = 4096,
  parameter int unsigned        AW       = 12,
  parameter logic [INSTR_W-1:0] CLR_WORD = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clearing_i,
  input  logic [AW-1:0]      clr_addr_i,
  input  logic               ld_we_i,
  input  logic [AW-1:0]      ld_addr_i,
  input  logic [INSTR_W-1:0] ld_data_i,
  input  logic               rd_en_i,
  input  logic [AW-1:0]      rd_addr_i,
  output logic [INSTR_W-1:0] rd_data_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] rd_q;

  logic               we;
  logic [AW-1:0]      waddr;
  logic [INSTR_W-1:0] wdata;

  // Write mux: the clear sweep owns the port while clearing, the loader otherwise.
  always_comb begin
    we    = ld_we_i;
    waddr = ld_addr_i;
    wdata = ld_data_i;
    if (clearing_i) begin
      we    = 1'b1;
      waddr = clr_addr_i;
      wdata = CLR_WORD;
    end
  end

  // Storage array; no reset, contents are initialised by the clear sweep.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read register: samples the array before this edge's write (read-first), holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rd_q <= '0;
    else if (rd_en_i) rd_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction store: post-reset clear sweep, handshaked
// program load, and a 1-cycle-latency range-checked fetch port.
module instr_mem_loadable
  import cpu_pkg::*;
#(
  parameter int unsigned        INSTR_W  = IMEM_INSTR_W,
  parameter int unsigned        ADDR_W   = IMEM_ADDR_W,
  parameter int unsigned        DEPTH    = 4096,
  parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(IMEM_NOP_WORD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  mem_ready,
  output logic                  prog_loaded,
  instr_mem_loadable_if.slave   bus
);

  localparam int unsigned       RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [RAM_AW-1:0] LAST_PTR = RAM_AW'(DEPTH - 1);

  imem_state_t       state_q, state_d;
  logic [RAM_AW-1:0] clr_ptr_q, clr_ptr_d;
  logic              prog_loaded_q, prog_loaded_d;
  logic              fetch_valid_q;
  logic              fetch_err_q;
  logic              ld_err_q;

  logic              running;
  logic              ld_accept;
  logic              ld_in_range;
  logic              fetch_fire;
  logic              fetch_in_range;
  logic [INSTR_W-1:0] ram_rdata;

  assign running        = (state_q == IMEM_RUN);
  assign ld_in_range    = ({1'b0, bus.ld_addr} < DEPTH_L);
  assign fetch_in_range = ({1'b0, bus.fetch_addr} < DEPTH_L);
  assign ld_accept      = bus.ld_valid & running;
  assign fetch_fire     = bus.fetch_req & running;

  // Next-state: sweep clr_ptr through every word, then serve until a clear request.
  always_comb begin
    state_d       = state_q;
    clr_ptr_d     = clr_ptr_q;
    prog_loaded_d = prog_loaded_q;
    unique case (state_q)
      IMEM_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_PTR) begin
          state_d   = IMEM_RUN;
          clr_ptr_d = '0;
        end
      end
      IMEM_RUN: begin
        if (clear_req) begin
          state_d       = IMEM_CLEAR;
          clr_ptr_d     = '0;
          prog_loaded_d = 1'b0;
        end else if (ld_accept && bus.ld_last) begin
          prog_loaded_d = 1'b1;
        end
      end
      default: begin
        state_d   = IMEM_CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  // State, sweep pointer and sticky program-loaded flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IMEM_CLEAR;
      clr_ptr_q     <= '0;
      prog_loaded_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      prog_loaded_q <= prog_loaded_d;
    end
  end

  // Fetch/load status: valid pulses per request, err holds with the returned word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      ld_err_q      <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_fire;
      if (fetch_fire) fetch_err_q <= ~fetch_in_range;
      ld_err_q      <= ld_accept & ~ld_in_range;
    end
  end

  imem_ram #(
    .INSTR_W  (INSTR_W),
    .DEPTH    (DEPTH),
    .AW       (RAM_AW),
    .CLR_WORD (NOP_WORD)
  ) u_ram (
    .clk        (clk),
    .rst        (rst),
    .clearing_i (~running),
    .clr_addr_i (clr_ptr_q),
    .ld_we_i    (ld_accept & ld_in_range),
    .ld_addr_i  (bus.ld_addr[RAM_AW-1:0]),
    .ld_data_i  (bus.ld_data),
    .rd_en_i    (fetch_fire & fetch_in_range),
    .rd_addr_i  (bus.fetch_addr[RAM_AW-1:0]),
    .rd_data_o  (ram_rdata)
  );

  // Out-of-range fetches never touch the RAM read register, so the NOP is
  // substituted here using the held error flag.
  assign bus.fetch_instr = fetch_err_q ? NOP_WORD : ram_rdata;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_err   = fetch_err_q;
  assign bus.ld_err      = ld_err_q;
  assign bus.ld_ready    = running;
  assign mem_ready       = running;
  assign prog_loaded     = prog_loaded_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed scoreboard bench for instr_mem_loadable (DEPTH=16, ADDR_W=12, INSTR_W=19).
module tb_instr_mem_loadable;

  localparam int unsigned AW    = 12;
  localparam int unsigned IW    = 19;
  localparam int unsigned DEPTH = 16;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic          err;
  } fexp_t;

  logic clk = 1'b0;
  logic rst;
  logic clear_req;
  logic mem_ready;
  logic prog_loaded;

  instr_mem_loadable_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  instr_mem_loadable #(
    .INSTR_W (IW),
    .ADDR_W  (AW),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear_req   (clear_req),
    .mem_ready   (mem_ready),
    .prog_loaded (prog_loaded),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int unsigned   tests = 0;
  int unsigned   fails = 0;
  fexp_t         sb[$];
  logic [IW-1:0] model [DEPTH];
  logic [IW-1:0] last_instr = '0;
  logic          last_err   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1ns after the edge and retire any pending fetch expectation.
  task automatic step();
    fexp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("fetch_valid", {31'b0, bus.fetch_valid}, 32'd1);
      check("fetch_instr", {13'b0, bus.fetch_instr}, {13'b0, e.instr});
      check("fetch_err",   {31'b0, bus.fetch_err},   {31'b0, e.err});
      last_instr = e.instr;
      last_err   = e.err;
    end else begin
      check("no_fetch_valid", {31'b0, bus.fetch_valid}, 32'd0);
    end
  endtask

  task automatic issue_fetch(input int unsigned addr);
    fexp_t e;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = AW'(addr);
    if (addr < DEPTH) begin
      e.instr = model[addr];
      e.err   = 1'b0;
    end else begin
      e.instr = '0;
      e.err   = 1'b1;
    end
    sb.push_back(e);
  endtask

  task automatic drive_load(input int unsigned addr, input logic [IW-1:0] data, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = AW'(addr);
    bus.ld_data  = data;
    bus.ld_last  = last;
    if (addr < DEPTH) model[addr] = data;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!mem_ready && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic model_clear();
    for (int unsigned i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  int n;

  initial begin
    model_clear();
    rst            = 1'b1;
    clear_req      = 1'b0;
    bus.ld_valid   = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
    bus.ld_last    = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_ready",   {31'b0, mem_ready},       32'd0);
    check("rst_prog_loaded", {31'b0, prog_loaded},     32'd0);
    check("rst_ld_ready",    {31'b0, bus.ld_ready},    32'd0);
    check("rst_ld_err",      {31'b0, bus.ld_err},      32'd0);
    check("rst_fetch_valid", {31'b0, bus.fetch_valid}, 32'd0);
    check("rst_fetch_instr", {13'b0, bus.fetch_instr}, 32'd0);
    check("rst_fetch_err",   {31'b0, bus.fetch_err},   32'd0);

    // Initial clear sweep takes DEPTH cycles.
    rst = 1'b0;
    wait_ready(n);
    check("clear_len_reset", n, DEPTH);
    check("ld_ready_run", {31'b0, bus.ld_ready}, 32'd1);

    // Cleared word reads back as zero.
    issue_fetch(5); step(); bus.fetch_req = 1'b0;

    // Load with last, then fetch it.
    drive_load(3, 19'h2A5C1, 1'b1); step(); bus.ld_valid = 1'b0;
    check("prog_loaded_set", {31'b0, prog_loaded}, 32'd1);
    check("ld_err_inrange",  {31'b0, bus.ld_err},  32'd0);
    issue_fetch(3); step(); bus.fetch_req = 1'b0;

    // Same-cycle load and fetch of addr 7: old word, then new word.
    issue_fetch(7);
    drive_load(7, 19'h11111, 1'b0);
    step();
    bus.ld_valid = 1'b0;
    issue_fetch(7); step(); bus.fetch_req = 1'b0;

    // Back-to-back fetches, then idle: outputs hold.
    issue_fetch(3); step();
    issue_fetch(7); step();
    bus.fetch_req = 1'b0; step();
    check("hold_instr", {13'b0, bus.fetch_instr}, {13'b0, last_instr});
    check("hold_err",   {31'b0, bus.fetch_err},   {31'b0, last_err});

    // Out-of-range fetches.
    issue_fetch(16); step();
    issue_fetch(4095); step();
    bus.fetch_req = 1'b0; step();
    check("hold_err_oob", {31'b0, bus.fetch_err}, 32'd1);
    check("hold_nop_oob", {13'b0, bus.fetch_instr}, 32'd0);

    // Out-of-range load: ld_err pulse, no aliasing write to addr 4.
    drive_load(20, 19'h7FFFF, 1'b0); step(); bus.ld_valid = 1'b0;
    check("ld_err_pulse", {31'b0, bus.ld_err}, 32'd1);
    step();
    check("ld_err_clear", {31'b0, bus.ld_err}, 32'd0);
    issue_fetch(4); step(); bus.fetch_req = 1'b0;

    // clear_req with a same-cycle fetch: fetch sees pre-clear contents.
    issue_fetch(3);
    clear_req = 1'b1;
    step();
    clear_req     = 1'b0;
    bus.fetch_req = 1'b0;
    model_clear();
    check("clr_mem_ready",   {31'b0, mem_ready},    32'd0);
    check("clr_prog_loaded", {31'b0, prog_loaded},  32'd0);
    check("clr_ld_ready",    {31'b0, bus.ld_ready}, 32'd0);
    // Requests during the sweep are ignored and loads are not accepted.
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = AW'(3);
    bus.ld_valid   = 1'b1;
    bus.ld_addr    = AW'(3);
    bus.ld_data    = 19'h55555;
    bus.ld_last    = 1'b1;
    wait_ready(n);
    bus.fetch_req = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_last   = 1'b0;
    check("clear_len_req", n, DEPTH);
    check("clr_no_prog_loaded", {31'b0, prog_loaded}, 32'd0);
    issue_fetch(3); step(); bus.fetch_req = 1'b0;

    // Reset in the middle of a clear sweep.
    drive_load(2, 19'h1ABCD, 1'b1); step(); bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    issue_fetch(2); step(); bus.fetch_req = 1'b0;
    clear_req = 1'b1; step(); clear_req = 1'b0;
    model_clear();
    repeat (8) step();
    check("clr_hold_instr", {13'b0, bus.fetch_instr}, {13'b0, 19'h1ABCD});
    rst = 1'b1;
    #1;
    check("arst_mem_ready",   {31'b0, mem_ready},       32'd0);
    check("arst_prog_loaded", {31'b0, prog_loaded},     32'd0);
    check("arst_fetch_instr", {13'b0, bus.fetch_instr}, 32'd0);
    check("arst_ld_ready",    {31'b0, bus.ld_ready},    32'd0);
    step(); step();
    rst = 1'b0;
    wait_ready(n);
    check("clear_len_rerun", n, DEPTH);
    issue_fetch(2); step(); bus.fetch_req = 1'b0;
    step();

    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
